// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV M-extension multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface exec_muldiv_unit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  i_start;
    logic [2:0]            i_func3;
    logic                  i_word;
    logic [DATA_WIDTH-1:0] i_src_1;
    logic [DATA_WIDTH-1:0] i_src_2;
    logic [REG_ADDR_W-1:0] i_rd_addr;
    logic                  i_flush;
    logic                  o_ready;
    logic                  o_busy;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_result;
    logic [REG_ADDR_W-1:0] o_rd_addr;

    modport master (
        output i_start, i_func3, i_word, i_src_1, i_src_2, i_rd_addr, i_flush,
        input  o_ready, o_busy, o_done, o_result, o_rd_addr
    );

    modport slave (
        input  i_start, i_func3, i_word, i_src_1, i_src_2, i_rd_addr, i_flush,
        output o_ready, o_busy, o_done, o_result, o_rd_addr
    );
endinterface

// File: rtl/iter_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step. The
// post-step values are exposed so the caller can latch the final step directly.
module iter_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr_q};
        // diff MSB set means the trial subtraction borrowed: restore
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
        end else if (step) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end
    end
endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RV M-extension unit: shift-add multiply, restoring divide, one bit
// per cycle on magnitudes with sign correction applied as the result latches.
module exec_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input logic               i_clk,
    input logic               i_rst,
    exec_muldiv_unit_if.slave bus
);
    localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;
    localparam int PROD_W  = 2 * DATA_WIDTH;
    localparam bit WORD_OK = (DATA_WIDTH == 64);

    function automatic logic [DATA_WIDTH-1:0] sext_word(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return DATA_WIDTH'(s);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [PROD_W-1:0] neg_prod_if(input logic [PROD_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    ready_q, busy_q, done_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [REG_ADDR_W-1:0]   tag_q;
    logic [2:0]              f3_q;
    logic                    word_q, neg_q;
    logic [DATA_WIDTH-1:0]   mcand_q, acc_hi_q, acc_lo_q;

    logic [2:0]              f3;
    logic                    accept, word_req, signed_a, signed_b, a_sign, b_sign;
    logic                    div_zero, div_ovf, special, res_neg;
    logic [DATA_WIDTH-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, special_res, dividend;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [PROD_W-1:0]       prod_nxt, prod_sel, prod_fix;
    logic [DATA_WIDTH-1:0]   mul_res, div_raw, div_res, calc_res, quo_nxt, rem_nxt;

    assign f3     = bus.i_func3;
    assign accept = (state == ST_IDLE) && bus.i_start && !bus.i_flush;

    // Request decode: operand extension, magnitudes and bypass cases
    always_comb begin
        word_req = WORD_OK && bus.i_word && (f3 == F3_MUL || is_div_op(f3));
        signed_a = !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
        signed_b = signed_a && (f3 != F3_MULHSU);
        if (word_req) begin
            a_ext   = signed_a ? sext_word(bus.i_src_1[31:0]) : DATA_WIDTH'(bus.i_src_1[31:0]);
            b_ext   = signed_b ? sext_word(bus.i_src_2[31:0]) : DATA_WIDTH'(bus.i_src_2[31:0]);
            min_val = sext_word(32'h8000_0000);
        end else begin
            a_ext   = bus.i_src_1;
            b_ext   = bus.i_src_2;
            min_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        a_sign   = signed_a && a_ext[DATA_WIDTH-1];
        b_sign   = signed_b && b_ext[DATA_WIDTH-1];
        a_mag    = neg_if(a_ext, a_sign);
        b_mag    = neg_if(b_ext, b_sign);
        // Remainder takes the dividend's sign; quotient and product the xor
        res_neg  = (f3 == F3_REM || f3 == F3_REMU) ? a_sign : (a_sign ^ b_sign);
        dividend = word_req ? (a_mag << (DATA_WIDTH - 32)) : a_mag;
        div_zero = is_div_op(f3) && (b_ext == '0);
        div_ovf  = (f3 == F3_DIV || f3 == F3_REM) && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = f3[1] ? a_ext : '1;
        else          special_res = f3[1] ? '0 : a_ext;
        if (word_req) special_res = sext_word(special_res[31:0]);
    end

    // Multiply step and final result selection from post-step values
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        prod_nxt = {mul_sum, acc_lo_q[DATA_WIDTH-1:1]};
        prod_sel = word_q ? (prod_nxt >> (DATA_WIDTH - 32)) : prod_nxt;
        prod_fix = neg_prod_if(prod_sel, neg_q);
        mul_res  = (f3_q == F3_MUL) ? prod_fix[DATA_WIDTH-1:0] : prod_fix[PROD_W-1:DATA_WIDTH];
        div_raw  = f3_q[1] ? rem_nxt : quo_nxt;
        div_res  = neg_if(div_raw, neg_q);
        calc_res = is_div_op(f3_q) ? div_res : mul_res;
        if (word_q) calc_res = sext_word(calc_res[31:0]);
    end

    iter_divider #(.WIDTH(DATA_WIDTH)) u_div (
        .clk      (i_clk),
        .load     (accept),
        .step     (state == ST_CALC),
        .dividend (dividend),
        .divisor  (b_mag),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (accept) begin
            f3_q     <= f3;
            word_q   <= word_req;
            neg_q    <= res_neg;
            mcand_q  <= a_mag;
            acc_hi_q <= '0;
            acc_lo_q <= b_mag;
        end else if (state == ST_CALC) begin
            acc_hi_q <= prod_nxt[PROD_W-1:DATA_WIDTH];
            acc_lo_q <= prod_nxt[DATA_WIDTH-1:0];
        end
    end

    // Control FSM; flush overrides everything except reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (bus.i_flush) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        tag_q   <= bus.i_rd_addr;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (special) begin
                            state    <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state <= ST_CALC;
                            cnt   <= word_req ? CNT_W'(32) : CNT_W'(DATA_WIDTH);
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= calc_res;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_result  = result_q;
    assign bus.o_rd_addr = tag_q;
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit at DATA_WIDTH=64.
module tb_exec_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exec_muldiv_unit_if #(.DATA_WIDTH(64), .REG_ADDR_W(5)) bus ();

    exec_muldiv_unit #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request, waits for o_done (bounded) and looks one cycle past it.
    task automatic run_op(input logic [2:0] f3, input logic wd, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          output int lat, output logic [63:0] res, output logic [4:0] rd,
                          output logic busy1, output logic done_nx, output logic ready_nx);
        bus.i_func3   = f3;
        bus.i_word    = wd;
        bus.i_src_1   = a;
        bus.i_src_2   = b;
        bus.i_rd_addr = tag;
        bus.i_start   = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        busy1 = bus.o_busy;
        lat = 1;
        while (bus.o_done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.o_result;
        rd  = bus.o_rd_addr;
        @(posedge clk); #1;
        done_nx  = bus.o_done;
        ready_nx = bus.o_ready;
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
        checks++; if (bus.o_result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
        checks++; if (bus.o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h expected 0", bus.o_rd_addr); end
        // Reset in the middle of a multiply must abort silently
        bus.i_func3 = F3_MUL; bus.i_word = 1'b0; bus.i_src_1 = 64'd3; bus.i_src_2 = 64'd5;
        bus.i_rd_addr = 5'd9; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_rd_addr !== 5'd0) begin errors++; $display("FAIL midrst_rd: got %h expected 0", bus.o_rd_addr); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.o_done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b expected 0", seen); end
        checks++; if (bus.o_result !== 64'h0) begin errors++; $display("FAIL midrst_result: got %h expected 0", bus.o_result); end
    endtask

    task automatic test_mul();
        int lat; logic [63:0] res; logic [4:0] rd; logic b1, dn, rn;
        run_op(F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_res: got %h expected ffffffffffffffeb", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL mul_lat: got %0d expected 65", lat); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b expected 1", b1); end
        checks++; if (dn !== 1'b0 || rn !== 1'b1) begin errors++; $display("FAIL mul_after: got done=%b ready=%b expected done=0 ready=1", dn, rn); end
        checks++; if (rd !== 5'd3) begin errors++; $display("FAIL mul_rd: got %h expected 3", rd); end
        run_op(F3_MUL, 1'b0, 64'h1234, 64'h10, 5'd4, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'h12340) begin errors++; $display("FAIL mul_pos: got %h expected 12340", res); end
        run_op(F3_MUL, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 5'd5, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mulw_res: got %h expected fffffffffffffffd", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulw_lat: got %0d expected 33", lat); end
    endtask

    task automatic test_mulh();
        int lat; logic [63:0] res; logic [4:0] rd; logic b1, dn, rn;
        run_op(F3_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mulh_res: got %h expected 4000000000000000", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL mulh_lat: got %0d expected 65", lat); end
        run_op(F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'd1) begin errors++; $display("FAIL mulhu_res: got %h expected 1", res); end
        run_op(F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_res: got %h expected ffffffffffffffff", res); end
    endtask

    task automatic test_div_special();
        int lat; logic [63:0] res; logic [4:0] rd; logic b1, dn, rn;
        run_op(F3_DIVU, 1'b0, 64'd5, 64'd0, 5'd10, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu0_res: got %h expected ffffffffffffffff", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu0_lat: got %0d expected 1", lat); end
        checks++; if (dn !== 1'b0 || rn !== 1'b1) begin errors++; $display("FAIL divu0_after: got done=%b ready=%b expected done=0 ready=1", dn, rn); end
        run_op(F3_REMU, 1'b0, 64'd5, 64'd0, 5'd11, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'd5) begin errors++; $display("FAIL remu0_res: got %h expected 5", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_lat: got %0d expected 1", lat); end
        run_op(F3_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL divovf_res: got %h expected 8000000000000000", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divovf_lat: got %0d expected 1", lat); end
        run_op(F3_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL removf_res: got %h expected 0", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL removf_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_div();
        int lat; logic [63:0] res; logic [4:0] rd; logic b1, dn, rn;
        run_op(F3_DIV, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd17, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divw_res: got %h expected fffffffffffffffd", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL divw_lat: got %0d expected 33", lat); end
        checks++; if (rd !== 5'd17) begin errors++; $display("FAIL divw_rd: got %0d expected 17", rd); end
        run_op(F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd18, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_res: got %h expected fffffffffffffffd", res); end
        checks++; if (lat !== 65) begin errors++; $display("FAIL div_lat: got %0d expected 65", lat); end
        run_op(F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd19, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_res: got %h expected ffffffffffffffff", res); end
        run_op(F3_REMU, 1'b0, 64'd100, 64'd7, 5'd20, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'd2) begin errors++; $display("FAIL remu_res: got %h expected 2", res); end
        run_op(F3_DIVU, 1'b0, 64'd100, 64'd7, 5'd21, lat, res, rd, b1, dn, rn);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL divu_res: got %h expected e", res); end
    endtask

    task automatic test_flush();
        logic seen;
        bus.i_func3 = F3_DIV; bus.i_word = 1'b0; bus.i_src_1 = 64'd100; bus.i_src_2 = 64'd7;
        bus.i_rd_addr = 5'd22; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.o_busy); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.o_done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_nodone: got %b expected 0", seen); end
        // Start and flush together: the request is dropped
        bus.i_func3 = F3_DIVU; bus.i_src_1 = 64'd5; bus.i_src_2 = 64'd0; bus.i_rd_addr = 5'd23;
        bus.i_start = 1'b1; bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_flush = 1'b0;
        checks++; if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_start: got ready=%b busy=%b expected ready=1 busy=0", bus.o_ready, bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL flush_start_done: got %b expected 0", bus.o_done); end
        checks++; if (bus.o_rd_addr === 5'd23) begin errors++; $display("FAIL flush_start_rd: got %0d expected not 23", bus.o_rd_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_func3 = 3'd0; bus.i_word = 1'b0;
        bus.i_src_1 = '0; bus.i_src_2 = '0; bus.i_rd_addr = '0; bus.i_flush = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div_special();
        test_div();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
